// File: rtl/dcache_controller.sv
// Direct-mapped, write-back, write-allocate L1 data cache controller.
// Sits between the MEM stage and a slow line-wide memory; stalls the whole
// pipeline combinationally while a miss is being serviced.
module dcache_controller #(
  parameter int NUM_LINES = 32,
  parameter int LINE_BITS = 128
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 cpu_read_i,
  input  logic                 cpu_write_i,
  input  logic [31:0]          cpu_addr_i,
  input  logic [31:0]          cpu_wdata_i,
  output logic [31:0]          cpu_rdata_o,
  output logic                 cpu_stall_o,
  output logic                 mem_enable_o,
  output logic                 mem_write_o,
  output logic [31:0]          mem_addr_o,
  output logic [LINE_BITS-1:0] mem_wdata_o,
  input  logic [LINE_BITS-1:0] mem_rdata_i,
  input  logic                 mem_ack_i
);
  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = 32 - 4 - IDX_W;

  typedef enum logic [1:0] {S_IDLE, S_WRITEBACK, S_ALLOCATE, S_REFILL} state_t;

  state_t r_state;
  state_t w_state_next;

  // Per-line bookkeeping; valid/dirty are flat vectors so reset clears them in one go.
  logic [NUM_LINES-1:0] r_valid;
  logic [NUM_LINES-1:0] r_dirty;
  logic [TAG_W-1:0]     r_tag  [NUM_LINES];
  logic [LINE_BITS-1:0] r_data [NUM_LINES];

  logic                 r_mem_enable;
  logic                 r_mem_write;
  logic [31:0]          r_mem_addr;
  logic [LINE_BITS-1:0] r_mem_wdata;
  logic                 w_mem_enable_next;
  logic                 w_mem_write_next;
  logic [31:0]          w_mem_addr_next;
  logic [LINE_BITS-1:0] w_mem_wdata_next;

  logic [1:0]       w_word;
  logic [IDX_W-1:0] w_index;
  logic [TAG_W-1:0] w_tag;
  logic             w_req;
  logic             w_hit;
  logic             w_write_hit;
  logic             w_wb_done;
  logic             w_fill;
  logic [31:0]      w_sel_word;
  logic             w_unused_addr;

  assign w_word        = cpu_addr_i[3:2];
  assign w_index       = cpu_addr_i[4 +: IDX_W];
  assign w_tag         = cpu_addr_i[31 -: TAG_W];
  assign w_unused_addr = ^cpu_addr_i[1:0];

  assign w_req       = cpu_read_i | cpu_write_i;
  assign w_hit       = r_valid[w_index] && (r_tag[w_index] == w_tag);
  assign w_sel_word  = r_data[w_index][{w_word, 5'b0} +: 32];
  assign w_write_hit = (r_state == S_IDLE) && cpu_write_i && w_hit;
  assign w_wb_done   = (r_state == S_WRITEBACK) && mem_ack_i;
  assign w_fill      = (r_state == S_ALLOCATE) && mem_ack_i;

  // A simultaneous read+write is a store, so it never returns load data.
  assign cpu_stall_o = w_req && ((r_state != S_IDLE) || !w_hit);
  assign cpu_rdata_o = (cpu_read_i && !cpu_write_i && w_hit && (r_state == S_IDLE)) ? w_sel_word : 32'd0;

  assign mem_enable_o = r_mem_enable;
  assign mem_write_o  = r_mem_write;
  assign mem_addr_o   = r_mem_addr;
  assign mem_wdata_o  = r_mem_wdata;

  // Next state and next memory request; memory outputs hold unless a transition changes them.
  always_comb begin
    w_state_next      = r_state;
    w_mem_enable_next = r_mem_enable;
    w_mem_write_next  = r_mem_write;
    w_mem_addr_next   = r_mem_addr;
    w_mem_wdata_next  = r_mem_wdata;
    case (r_state)
      S_IDLE: begin
        if (w_req && !w_hit) begin
          w_mem_enable_next = 1'b1;
          if (r_valid[w_index] && r_dirty[w_index]) begin
            w_state_next     = S_WRITEBACK;
            w_mem_write_next = 1'b1;
            w_mem_addr_next  = {r_tag[w_index], w_index, 4'b0};
            w_mem_wdata_next = r_data[w_index];
          end else begin
            w_state_next     = S_ALLOCATE;
            w_mem_write_next = 1'b0;
            w_mem_addr_next  = {w_tag, w_index, 4'b0};
          end
        end
      end
      S_WRITEBACK: begin
        if (mem_ack_i) begin
          w_state_next      = S_ALLOCATE;
          w_mem_enable_next = 1'b1;
          w_mem_write_next  = 1'b0;
          w_mem_addr_next   = {w_tag, w_index, 4'b0};
        end
      end
      S_ALLOCATE: begin
        if (mem_ack_i) begin
          w_state_next      = S_REFILL;
          w_mem_enable_next = 1'b0;
        end
      end
      S_REFILL: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Control state, valid/dirty bits and the registered memory request.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state      <= S_IDLE;
      r_valid      <= '0;
      r_dirty      <= '0;
      r_mem_enable <= 1'b0;
      r_mem_write  <= 1'b0;
      r_mem_addr   <= 32'd0;
      r_mem_wdata  <= '0;
    end else begin
      r_state      <= w_state_next;
      r_mem_enable <= w_mem_enable_next;
      r_mem_write  <= w_mem_write_next;
      r_mem_addr   <= w_mem_addr_next;
      r_mem_wdata  <= w_mem_wdata_next;
      if (w_write_hit) begin
        r_dirty[w_index] <= 1'b1;
      end
      if (w_wb_done) begin
        r_dirty[w_index] <= 1'b0;
      end
      if (w_fill) begin
        r_valid[w_index] <= 1'b1;
        r_dirty[w_index] <= 1'b0;
      end
    end
  end

  // Tag and data arrays; contents need no reset because valid gates every use.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      if (w_fill) begin
        r_tag[w_index]  <= w_tag;
        r_data[w_index] <= mem_rdata_i;
      end else if (w_write_hit) begin
        r_data[w_index][{w_word, 5'b0} +: 32] <= cpu_wdata_i;
      end
    end
  end
endmodule

// File: tb/tb_dcache_controller.sv
// Bench for dcache_controller: a memory responder, a CPU-visible value model
// (latest written word, else memory contents) and a line-residency model.
module tb_dcache_controller;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         cpu_read = 1'b0;
  logic         cpu_write = 1'b0;
  logic [31:0]  cpu_addr = 32'd0;
  logic [31:0]  cpu_wdata = 32'd0;
  logic [31:0]  cpu_rdata;
  logic         cpu_stall;
  logic         mem_enable;
  logic         mem_write;
  logic [31:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata;
  logic         mem_ack;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  dcache_controller #(.NUM_LINES(32), .LINE_BITS(128)) dut (
    .clk_i(clk), .rst_i(rst),
    .cpu_read_i(cpu_read), .cpu_write_i(cpu_write),
    .cpu_addr_i(cpu_addr), .cpu_wdata_i(cpu_wdata),
    .cpu_rdata_o(cpu_rdata), .cpu_stall_o(cpu_stall),
    .mem_enable_o(mem_enable), .mem_write_o(mem_write),
    .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_rdata_i(mem_rdata), .mem_ack_i(mem_ack)
  );

  logic [127:0] mem_lines [int];
  logic [31:0]  shadow [int];
  logic         m_valid [32];
  logic         m_dirty [32];
  logic [22:0]  m_tag [32];

  int           ack_delay = 5;
  int           wb_cnt = 0;
  int           fetch_cnt = 0;
  int           late_req = 0;
  int           late_done = 0;
  logic [31:0]  wb_addr = 32'd0;
  logic [31:0]  fetch_addr = 32'd0;
  logic [127:0] wb_data = '0;

  // Initial memory image: line 0x100 holds words 1..4, others a pattern of the address.
  function automatic logic [31:0] init_word(input logic [31:0] a);
    if (a[31:4] == 28'h10) return {30'd0, a[3:2]} + 32'd1;
    return {a[31:2], 2'b00} ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [127:0] mem_line(input logic [31:0] a);
    logic [127:0] l;
    int key;
    key = int'({4'd0, a[31:4]});
    if (mem_lines.exists(key)) return mem_lines[key];
    for (int k = 0; k < 4; k++) l[k*32 +: 32] = init_word({a[31:4], k[1:0], 2'b00});
    return l;
  endfunction

  // What a load of this address must return.
  function automatic logic [31:0] cpu_view(input logic [31:0] a);
    logic [127:0] l;
    int key;
    key = int'({2'd0, a[31:2]});
    if (shadow.exists(key)) return shadow[key];
    l = mem_line(a);
    return l[{a[3:2], 5'b0} +: 32];
  endfunction

  task automatic chk32(input string nm, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic chk128(input string nm, input logic [127:0] got, input logic [127:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
      m_tag[i]   = 23'd0;
    end
    shadow.delete();
  endtask

  // Memory responder: acks each request after ack_delay cycles of mem_enable_o.
  initial begin
    int wait_cnt;
    wait_cnt  = 0;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      mem_ack = 1'b0;
      if (late_req != late_done) begin
        mem_ack   = 1'b1;
        mem_rdata = {4{32'hBAD0_BAD0}};
        late_done++;
      end else if (mem_enable && !rst) begin
        wait_cnt++;
        if (wait_cnt >= ack_delay) begin
          wait_cnt = 0;
          if (mem_write) begin
            wb_cnt++;
            wb_addr = mem_addr;
            wb_data = mem_wdata;
            mem_lines[int'({4'd0, mem_addr[31:4]})] = mem_wdata;
          end else begin
            fetch_cnt++;
            fetch_addr = mem_addr;
            mem_rdata  = mem_line(mem_addr);
          end
          mem_ack = 1'b1;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // Per-cycle compare against the value model.
  always @(negedge clk) begin
    if (!rst) begin
      if (cpu_read || cpu_write) begin
        if (!cpu_stall)
          chk32("rdata", cpu_rdata, (cpu_read && !cpu_write) ? cpu_view(cpu_addr) : 32'd0);
      end else begin
        chk32("idle_stall", {31'd0, cpu_stall}, 32'd0);
        chk32("idle_rdata", cpu_rdata, 32'd0);
      end
      if (mem_enable) chk32("mem_addr_align", {28'd0, mem_addr[3:0]}, 32'd0);
    end
  end

  // One CPU access held until the stall drops, then checked against the residency model.
  task automatic access(input string nm, input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] wd, input logic chk_rd, input logic [31:0] exp_rd,
                        output int n);
    logic [4:0]   idx;
    logic [22:0]  tg;
    logic         hit;
    logic         exp_wb;
    logic [31:0]  vic_addr;
    logic [127:0] vic_line;
    logic [31:0]  got;
    int           wb0;
    int           f0;
    idx      = a[8:4];
    tg       = a[31:9];
    hit      = m_valid[idx] && (m_tag[idx] == tg);
    exp_wb   = !hit && m_valid[idx] && m_dirty[idx];
    vic_addr = {m_tag[idx], idx, 4'b0};
    for (int k = 0; k < 4; k++) vic_line[k*32 +: 32] = cpu_view({m_tag[idx], idx, k[1:0], 2'b00});
    wb0 = wb_cnt;
    f0  = fetch_cnt;
    n   = 0;
    @(posedge clk); #1;
    cpu_read  = rd;
    cpu_write = wr;
    cpu_addr  = a;
    cpu_wdata = wd;
    forever begin
      @(negedge clk);
      if (!cpu_stall) break;
      n++;
      if (n > 200) break;
    end
    got = cpu_rdata;
    @(posedge clk); #1;
    cpu_read  = 1'b0;
    cpu_write = 1'b0;
    if (wr) shadow[int'({2'd0, a[31:2]})] = wd;
    m_dirty[idx] = wr ? 1'b1 : (hit ? m_dirty[idx] : 1'b0);
    m_valid[idx] = 1'b1;
    m_tag[idx]   = tg;
    if (n > 200) chk32({nm, "_timeout"}, 32'd1, 32'd0);
    if (hit) chk32({nm, "_hit_stall"}, n, 32'd0);
    else     chk32({nm, "_miss_stalled"}, {31'd0, (n > 0)}, 32'd1);
    chk32({nm, "_wb_count"}, wb_cnt - wb0, {31'd0, exp_wb});
    chk32({nm, "_fetch_count"}, fetch_cnt - f0, {31'd0, !hit});
    if (exp_wb) begin
      chk32({nm, "_wb_addr"}, wb_addr, vic_addr);
      chk128({nm, "_wb_data"}, wb_data, vic_line);
    end
    if (!hit) chk32({nm, "_fetch_addr"}, fetch_addr, {tg, idx, 4'b0});
    if (chk_rd) chk32({nm, "_rdata_lit"}, got, exp_rd);
  endtask

  initial begin
    int n;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk32("rst_stall", {31'd0, cpu_stall}, 32'd0);
    chk32("rst_rdata", cpu_rdata, 32'd0);
    chk32("rst_mem_en", {31'd0, mem_enable}, 32'd0);
    chk32("rst_mem_wr", {31'd0, mem_write}, 32'd0);
    chk32("rst_mem_addr", mem_addr, 32'd0);
    chk128("rst_mem_wdata", mem_wdata, 128'd0);

    ack_delay = 5;
    access("cold_rd", 1'b1, 1'b0, 32'h0000_0104, 32'd0, 1'b1, 32'd2, n);
    chk32("cold_rd_stall_cycles", n, 32'd7);
    chk32("cold_rd_fetch_lit", fetch_addr, 32'h0000_0100);
    access("wr_hit", 1'b0, 1'b1, 32'h0000_0108, 32'hDEAD_BEEF, 1'b0, 32'd0, n);
    access("rd_hit", 1'b1, 1'b0, 32'h0000_0108, 32'd0, 1'b1, 32'hDEAD_BEEF, n);

    ack_delay = 3;
    access("dirty_conf", 1'b1, 1'b0, 32'h0000_0308, 32'd0, 1'b1, 32'h5A5A_0308, n);
    chk32("dirty_conf_wb_lit", wb_addr, 32'h0000_0100);
    chk32("dirty_conf_wb_word2", wb_data[95:64], 32'hDEAD_BEEF);
    chk32("dirty_conf_fetch_lit", fetch_addr, 32'h0000_0300);
    access("clean_conf", 1'b1, 1'b0, 32'h0000_0104, 32'd0, 1'b1, 32'd2, n);
    access("rd_after_wb", 1'b1, 1'b0, 32'h0000_0108, 32'd0, 1'b1, 32'hDEAD_BEEF, n);
    access("rw_both", 1'b1, 1'b1, 32'h0000_0100, 32'h1234_5678, 1'b1, 32'd0, n);
    access("rd_merged", 1'b1, 1'b0, 32'h0000_0100, 32'd0, 1'b1, 32'h1234_5678, n);
    access("wr_miss", 1'b0, 1'b1, 32'h0000_2004, 32'hCAFE_0001, 1'b0, 32'd0, n);
    access("rd_wr_miss", 1'b1, 1'b0, 32'h0000_2004, 32'd0, 1'b1, 32'hCAFE_0001, n);
    access("wr_miss_wb", 1'b0, 1'b1, 32'h0000_4004, 32'h0BAD_F00D, 1'b0, 32'd0, n);
    chk32("wr_miss_wb_lit", wb_addr, 32'h0000_2000);

    // Reset while a fetch is outstanding.
    ack_delay = 1000;
    @(posedge clk); #1;
    cpu_read = 1'b1;
    cpu_addr = 32'h0000_0534;
    repeat (3) @(negedge clk);
    chk32("alloc_pending_en", {31'd0, mem_enable}, 32'd1);
    chk32("alloc_pending_stall", {31'd0, cpu_stall}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    cpu_read = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    chk32("mid_rst_mem_en", {31'd0, mem_enable}, 32'd0);
    chk32("mid_rst_mem_wr", {31'd0, mem_write}, 32'd0);
    chk32("mid_rst_mem_addr", mem_addr, 32'd0);
    chk128("mid_rst_mem_wdata", mem_wdata, 128'd0);
    chk32("mid_rst_stall", {31'd0, cpu_stall}, 32'd0);
    late_req++;
    repeat (3) @(negedge clk);
    chk32("late_ack_mem_en", {31'd0, mem_enable}, 32'd0);
    ack_delay = 2;
    access("rd_after_rst", 1'b1, 1'b0, 32'h0000_0534, 32'd0, 1'b1, 32'h5A5A_0534, n);
    access("lost_dirty_100", 1'b1, 1'b0, 32'h0000_0100, 32'd0, 1'b1, 32'd1, n);
    access("lost_dirty_4004", 1'b1, 1'b0, 32'h0000_4004, 32'd0, 1'b1, 32'h5A5A_4004, n);

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
